// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller: computes X^E mod M by sequencing Montgomery products.
// Optional MODEXP_FINAL_CONV_EN adds a trailing multiply-by-one that converts the result out of Montgomery form.
module mod_exp_ctrl #(
    parameter int WIDTH   = 1024,
    parameter int E_WIDTH = 1024,
    parameter int CNT_W   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   x_mont,
    input  logic [WIDTH-1:0]   r_mod_m,
    input  logic [E_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]   modulus,
    output logic               mm_start,
    output logic [WIDTH-1:0]   mm_a,
    output logic [WIDTH-1:0]   mm_b,
    output logic [WIDTH-1:0]   mm_m,
    input  logic               mm_done,
    input  logic [WIDTH-1:0]   mm_result,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SQR_GO,
        S_SQR_WAIT,
        S_MUL_GO,
        S_MUL_WAIT,
`ifdef MODEXP_FINAL_CONV_EN
        S_CONV_GO,
        S_CONV_WAIT,
`endif
        S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [E_WIDTH-1:0]   e_q, e_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic                 mm_start_q, mm_start_d;
    logic [WIDTH-1:0]     mm_a_q, mm_a_d;
    logic [WIDTH-1:0]     mm_b_q, mm_b_d;
    logic [WIDTH-1:0]     mm_m_q, mm_m_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 issue_sqr, issue_mul, issue_end;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        x_d        = x_q;
        e_d        = e_q;
        m_d        = m_q;
        idx_d      = idx_q;
        mm_start_d = 1'b0;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;
        mm_m_d     = mm_m_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        issue_sqr  = 1'b0;
        issue_mul  = 1'b0;
        issue_end  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x_mont;
                    e_d     = exponent;
                    m_d     = modulus;
                    acc_d   = r_mod_m;
                    idx_d   = CNT_W'(E_WIDTH - 1);
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD:     issue_sqr = 1'b1;
            S_SQR_GO:   state_d = S_SQR_WAIT;
            S_SQR_WAIT: begin
                if (mm_done) begin
                    acc_d = mm_result;
                    if (e_q[idx_q]) begin
                        issue_mul = 1'b1;
                    end else if (idx_q != '0) begin
                        idx_d     = idx_q - CNT_W'(1);
                        issue_sqr = 1'b1;
                    end else begin
                        issue_end = 1'b1;
                    end
                end
            end
            S_MUL_GO:   state_d = S_MUL_WAIT;
            S_MUL_WAIT: begin
                if (mm_done) begin
                    acc_d = mm_result;
                    if (idx_q != '0) begin
                        idx_d     = idx_q - CNT_W'(1);
                        issue_sqr = 1'b1;
                    end else begin
                        issue_end = 1'b1;
                    end
                end
            end
`ifdef MODEXP_FINAL_CONV_EN
            S_CONV_GO:  state_d = S_CONV_WAIT;
            S_CONV_WAIT: begin
                if (mm_done) begin
                    acc_d   = mm_result;
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default:    state_d = S_IDLE;
        endcase

        // Operands are loaded on entry to a GO state from the freshly updated accumulator,
        // so they are stable for the whole GO cycle and the wait that follows.
        if (issue_sqr) begin
            state_d    = S_SQR_GO;
            mm_start_d = 1'b1;
            mm_a_d     = acc_d;
            mm_b_d     = acc_d;
            mm_m_d     = m_q;
        end
        if (issue_mul) begin
            state_d    = S_MUL_GO;
            mm_start_d = 1'b1;
            mm_a_d     = acc_d;
            mm_b_d     = x_q;
            mm_m_d     = m_q;
        end
        if (issue_end) begin
`ifdef MODEXP_FINAL_CONV_EN
            state_d    = S_CONV_GO;
            mm_start_d = 1'b1;
            mm_a_d     = acc_d;
            mm_b_d     = WIDTH'(1);
            mm_m_d     = m_q;
`else
            state_d    = S_FIN;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            x_q        <= '0;
            e_q        <= '0;
            m_q        <= '0;
            idx_q      <= '0;
            mm_start_q <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            mm_m_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            x_q        <= x_d;
            e_q        <= e_d;
            m_q        <= m_d;
            idx_q      <= idx_d;
            mm_start_q <= mm_start_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
            mm_m_q     <= mm_m_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign mm_start = mm_start_q;
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign mm_m     = mm_m_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a behavioural Montgomery multiplier (R = 2^16, fixed latency).
// Expected values follow MODEXP_FINAL_CONV_EN when it is defined for the build.
module tb_mod_exp_ctrl;
    localparam int W  = 16;
    localparam int EW = 4;
    localparam int CW = 2;
    localparam int L  = 5;

`ifdef MODEXP_FINAL_CONV_EN
    localparam int           EXTRA = 1;
    localparam logic [W-1:0] RES_A = 16'd6;
    localparam logic [W-1:0] RES_Z = 16'd1;
    localparam logic [W-1:0] RES_B = 16'd5;
`else
    localparam int           EXTRA = 0;
    localparam logic [W-1:0] RES_A = 16'd5;
    localparam logic [W-1:0] RES_Z = 16'd3;
    localparam logic [W-1:0] RES_B = 16'd1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  x_mont, r_mod_m, modulus;
    logic [EW-1:0] exponent;
    logic          mm_start;
    logic [W-1:0]  mm_a, mm_b, mm_m;
    logic          mm_done;
    logic [W-1:0]  mm_result;
    logic          busy, done;
    logic [W-1:0]  result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_exp_ctrl #(.WIDTH(W), .E_WIDTH(EW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x_mont(x_mont), .r_mod_m(r_mod_m), .exponent(exponent), .modulus(modulus),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_done(mm_done), .mm_result(mm_result),
        .busy(busy), .done(done), .result(result)
    );

    // Multiplier model: done is raised in wait cycle L after each mm_start.
    int           pulse_total = 0;
    int           bad_cnt = 0;
    int           rem = 0;
    logic         done_m = 1'b0;
    logic         force_done = 1'b0;
    logic [W-1:0] exp_m = '0;
    logic [W-1:0] lat_a = '0, lat_b = '0, prod = '0;

    assign mm_done   = done_m | force_done;
    assign mm_result = done_m ? prod : 16'hBEEF;

    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
        logic [63:0] t;
        if (m == '0) return '0;
        t = (64'(a) * 64'(b)) % 64'(m);
        for (int i = 0; i < W; i++) begin
            if (t[0]) t = t + 64'(m);
            t = t >> 1;
        end
        return t[W-1:0];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rem    <= 0;
            done_m <= 1'b0;
        end else if (mm_start) begin
            pulse_total <= pulse_total + 1;
            if (mm_m !== exp_m) bad_cnt <= bad_cnt + 1;
            lat_a  <= mm_a;
            lat_b  <= mm_b;
            prod   <= mont(mm_a, mm_b, mm_m);
            rem    <= L - 1;
            done_m <= (L == 1);
        end else if (rem > 0) begin
            if (mm_a !== lat_a || mm_b !== lat_b) bad_cnt <= bad_cnt + 1;
            rem    <= rem - 1;
            done_m <= (rem == 1);
        end else begin
            done_m <= 1'b0;
        end
    end

    // Caller must be at a negedge; returns at the negedge of the done cycle (lat = -1 on timeout).
    task automatic run_op(input logic [W-1:0] xm, input logic [W-1:0] rm, input logic [EW-1:0] e,
                          input logic [W-1:0] m, input bit disturb,
                          output int lat, output int pulses, output int busy_err, output int held_err);
        int           p0;
        logic [W-1:0] res0;
        p0 = pulse_total;
        res0 = result;
        lat = -1;
        busy_err = 0;
        held_err = 0;
        x_mont = xm; r_mod_m = rm; exponent = e; modulus = m; exp_m = m;
        start = 1'b1;
        force_done = disturb;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc;
                if (busy !== 1'b0) busy_err++;
                break;
            end
            if (busy !== 1'b1) busy_err++;
            if (result !== res0) held_err++;
            start      = disturb && (mm_start || (cyc % 3 == 0));
            force_done = disturb && (mm_start || cyc == 1);
        end
        start = 1'b0;
        force_done = 1'b0;
        pulses = pulse_total - p0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; force_done = 1'b0;
        x_mont = '0; r_mod_m = '0; exponent = '0; modulus = '0;
        @(negedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (mm_start !== 1'b0) begin errors++; $display("FAIL reset_mm_start got %0b exp 0", mm_start); end
        checks++; if (result !== 16'd0) begin errors++; $display("FAIL reset_result got %0d exp 0", result); end
        checks++; if ((mm_a | mm_b | mm_m) !== 16'd0) begin errors++; $display("FAIL reset_operands got %0h/%0h/%0h exp 0", mm_a, mm_b, mm_m); end
        reset = 1'b0;
        $display("test_reset: busy=%0b done=%0b result=%0d", busy, done, result);
    endtask

    task automatic test_modexp();
        int lat, pulses, berr, herr, bad0;
        bad0 = bad_cnt;
        @(negedge clk);
        run_op(16'd6, 16'd3, 4'b0101, 16'd13, 1'b0, lat, pulses, berr, herr);
        checks++; if (result !== RES_A) begin errors++; $display("FAIL modexp_result got %0d exp %0d", result, RES_A); end
        checks++; if (pulses !== 6 + EXTRA) begin errors++; $display("FAIL modexp_pulses got %0d exp %0d", pulses, 6 + EXTRA); end
        checks++; if (lat !== 3 + (6 + EXTRA) * (1 + L)) begin errors++; $display("FAIL modexp_latency got %0d exp %0d", lat, 3 + (6 + EXTRA) * (1 + L)); end
        checks++; if (berr !== 0) begin errors++; $display("FAIL modexp_busy got %0d bad cycles exp 0", berr); end
        checks++; if (herr !== 0) begin errors++; $display("FAIL modexp_result_held got %0d changes exp 0", herr); end
        checks++; if (bad_cnt - bad0 !== 0) begin errors++; $display("FAIL modexp_operands got %0d bad exp 0", bad_cnt - bad0); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL modexp_done_pulse got %0b exp 0", done); end
        checks++; if (result !== RES_A) begin errors++; $display("FAIL modexp_result_hold got %0d exp %0d", result, RES_A); end
        $display("test_modexp: E=0101 M=13 result=%0d pulses=%0d latency=%0d", result, pulses, lat);
    endtask

    task automatic test_zero_exp();
        int lat, pulses, berr, herr;
        @(negedge clk);
        run_op(16'd6, 16'd3, 4'b0000, 16'd13, 1'b0, lat, pulses, berr, herr);
        checks++; if (result !== RES_Z) begin errors++; $display("FAIL zero_exp_result got %0d exp %0d", result, RES_Z); end
        checks++; if (pulses !== 4 + EXTRA) begin errors++; $display("FAIL zero_exp_pulses got %0d exp %0d", pulses, 4 + EXTRA); end
        checks++; if (lat !== 3 + (4 + EXTRA) * (1 + L)) begin errors++; $display("FAIL zero_exp_latency got %0d exp %0d", lat, 3 + (4 + EXTRA) * (1 + L)); end
        $display("test_zero_exp: E=0000 result=%0d pulses=%0d latency=%0d", result, pulses, lat);
    endtask

    task automatic test_disturb();
        int lat, pulses, berr, herr, bad0;
        bad0 = bad_cnt;
        @(negedge clk);
        run_op(16'd6, 16'd3, 4'b0101, 16'd13, 1'b1, lat, pulses, berr, herr);
        checks++; if (result !== RES_A) begin errors++; $display("FAIL disturb_result got %0d exp %0d", result, RES_A); end
        checks++; if (pulses !== 6 + EXTRA) begin errors++; $display("FAIL disturb_pulses got %0d exp %0d", pulses, 6 + EXTRA); end
        checks++; if (lat !== 3 + (6 + EXTRA) * (1 + L)) begin errors++; $display("FAIL disturb_latency got %0d exp %0d", lat, 3 + (6 + EXTRA) * (1 + L)); end
        checks++; if (bad_cnt - bad0 !== 0) begin errors++; $display("FAIL disturb_operands got %0d bad exp 0", bad_cnt - bad0); end
        $display("test_disturb: start/mm_done noise result=%0d pulses=%0d latency=%0d", result, pulses, lat);
    endtask

    task automatic test_back_to_back();
        int lat, pulses, berr, herr;
        @(negedge clk);
        run_op(16'd6, 16'd3, 4'b0101, 16'd13, 1'b0, lat, pulses, berr, herr);
        checks++; if (result !== RES_A) begin errors++; $display("FAIL b2b_first_result got %0d exp %0d", result, RES_A); end
        // Next start is driven in the done cycle itself.
        run_op(16'd5, 16'd9, 4'b0011, 16'd11, 1'b0, lat, pulses, berr, herr);
        checks++; if (herr !== 0) begin errors++; $display("FAIL b2b_result_held got %0d changes exp 0", herr); end
        checks++; if (result !== RES_B) begin errors++; $display("FAIL b2b_second_result got %0d exp %0d", result, RES_B); end
        checks++; if (pulses !== 6 + EXTRA) begin errors++; $display("FAIL b2b_pulses got %0d exp %0d", pulses, 6 + EXTRA); end
        checks++; if (lat !== 3 + (6 + EXTRA) * (1 + L)) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", lat, 3 + (6 + EXTRA) * (1 + L)); end
        $display("test_back_to_back: second E=0011 M=11 result=%0d latency=%0d", result, lat);
    endtask

    task automatic test_reset_mid();
        int p0, p1, lat, pulses, berr, herr, dones;
        bit reached;
        @(negedge clk);
        checks++; if (result !== RES_B) begin errors++; $display("FAIL mid_prior_result got %0d exp %0d", result, RES_B); end
        p0 = pulse_total;
        x_mont = 16'd6; r_mod_m = 16'd3; exponent = 4'b0101; modulus = 16'd13; exp_m = 16'd13;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (pulse_total - p0 >= 3) begin reached = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (reached !== 1'b1) begin errors++; $display("FAIL mid_reach_mul got %0d pulses exp 3", pulse_total - p0); end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b exp 0", busy); end
        checks++; if (mm_start !== 1'b0) begin errors++; $display("FAIL mid_mm_start got %0b exp 0", mm_start); end
        checks++; if (result !== 16'd0) begin errors++; $display("FAIL mid_result got %0d exp 0", result); end
        @(negedge clk);
        reset = 1'b0;
        p1 = pulse_total;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++; if (dones !== 0 || pulse_total !== p1) begin errors++; $display("FAIL mid_quiet got %0d dones %0d pulses exp 0", dones, pulse_total - p1); end
        run_op(16'd6, 16'd3, 4'b0101, 16'd13, 1'b0, lat, pulses, berr, herr);
        checks++; if (result !== RES_A) begin errors++; $display("FAIL mid_rerun_result got %0d exp %0d", result, RES_A); end
        checks++; if (lat !== 3 + (6 + EXTRA) * (1 + L)) begin errors++; $display("FAIL mid_rerun_latency got %0d exp %0d", lat, 3 + (6 + EXTRA) * (1 + L)); end
        $display("test_reset_mid: rerun result=%0d latency=%0d", result, lat);
    endtask

    initial begin
        test_reset();
        test_modexp();
        test_zero_exp();
        test_disturb();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
